// File: rtl/grf_scoreboard.sv
// General register file with a per-register busy scoreboard, N combinational
// read ports with write bypass, two prioritised write ports and an issue port.
module grf_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr0_ok, wr1_ok, iss_ok;

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  // wr0 is suppressed when wr1 targets the same register so wr1 alone lands.
  assign wr1_ok = wr1_en & reset_n & writable(wr1_addr);
  assign wr0_ok = wr0_en & reset_n & writable(wr0_addr)
                  & ~(wr1_en & (wr1_addr == wr0_addr));
  assign iss_ok = iss_en & reset_n & writable(iss_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      if (wr0_ok) regs_q[wr0_addr] <= wr0_data;
      if (wr1_ok) regs_q[wr1_addr] <= wr1_data;
    end
  end

  // Writes clear busy, then a same-cycle issue sets it again (issue wins).
  always_comb begin
    busy_d = busy_q;
    if (wr0_ok) busy_d[wr0_addr] = 1'b0;
    if (wr1_ok) busy_d[wr1_addr] = 1'b0;
    if (iss_ok) busy_d[iss_addr] = 1'b1;
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic              hit1, hit0;
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    hit1    = 1'b0;
    hit0    = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra   = rd_addr[k*ADDR_W +: ADDR_W];
      hit1 = wr1_en && (wr1_addr == ra);
      hit0 = wr0_en && (wr0_addr == ra);
      if (reset_n) begin
        if (!writable(ra))
          rd_data[k*DATA_W +: DATA_W] = '0;
        else if (hit1)
          rd_data[k*DATA_W +: DATA_W] = wr1_data;
        else if (hit0)
          rd_data[k*DATA_W +: DATA_W] = wr0_data;
        else
          rd_data[k*DATA_W +: DATA_W] = regs_q[ra];
        rd_busy[k] = busy_q[ra] & ~(hit1 | hit0);
      end
    end
  end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench: vector table on the default configuration, hand sequences for
// reset-in-flight and a 16/3/4/no-zero-register configuration.
module tb_grf_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr0_en, wr1_en, iss_en;
  logic [4:0]  wr0_addr, wr1_addr, iss_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [5:0]  busy_cnt;

  logic [11:0] b_rd_addr;
  logic [63:0] b_rd_data;
  logic [3:0]  b_rd_busy;
  logic        b_wr0_en, b_wr1_en, b_iss_en;
  logic [2:0]  b_wr0_addr, b_wr1_addr, b_iss_addr;
  logic [15:0] b_wr0_data, b_wr1_data;
  logic [3:0]  b_busy_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  grf_scoreboard dut_a (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt)
  );

  grf_scoreboard #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr0_en(b_wr0_en), .wr0_addr(b_wr0_addr), .wr0_data(b_wr0_data),
    .wr1_en(b_wr1_en), .wr1_addr(b_wr1_addr), .wr1_data(b_wr1_data),
    .iss_en(b_iss_en), .iss_addr(b_iss_addr), .busy_cnt(b_busy_cnt)
  );

  typedef struct {
    logic        w0e; logic [4:0] w0a; logic [31:0] w0d;
    logic        w1e; logic [4:0] w1a; logic [31:0] w1d;
    logic        ie;  logic [4:0] ia;
    logic [4:0]  ra0, ra1;
    logic [31:0] ed0, ed1;
    logic [1:0]  eb;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                              input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                              input logic ie, input logic [4:0] ia,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [31:0] ed0, input logic [31:0] ed1,
                              input logic [1:0] eb, input logic [5:0] ecnt);
    vec_t v;
    v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
    v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
    v.ie = ie; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1;
    v.ed0 = ed0; v.ed1 = ed1; v.eb = eb; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_a();
    wr0_en = 0; wr0_addr = 0; wr0_data = 0;
    wr1_en = 0; wr1_addr = 0; wr1_data = 0;
    iss_en = 0; iss_addr = 0;
  endtask

  task automatic idle_b();
    b_wr0_en = 0; b_wr0_addr = 0; b_wr0_data = 0;
    b_wr1_en = 0; b_wr1_addr = 0; b_wr1_data = 0;
    b_iss_en = 0; b_iss_addr = 0; b_rd_addr = 0;
  endtask

  initial begin
    //            w0e w0a w0d            w1e w1a w1d            ie ia ra0 ra1 ed0            ed1            eb     cnt
    tbl[0]  = mk(0,  0,  0,             0,  0,  0,             0, 0, 3,  0,  0,             0,             2'b00, 0);
    tbl[1]  = mk(1,  3,  32'h1234_5678, 0,  0,  0,             0, 0, 3,  5,  32'h1234_5678, 0,             2'b00, 0);
    tbl[2]  = mk(0,  0,  0,             0,  0,  0,             0, 0, 3,  3,  32'h1234_5678, 32'h1234_5678, 2'b00, 0);
    tbl[3]  = mk(1,  5,  32'hAAAA_AAAA, 1,  5,  32'h5555_5555, 0, 0, 5,  3,  32'h5555_5555, 32'h1234_5678, 2'b00, 0);
    tbl[4]  = mk(0,  0,  0,             0,  0,  0,             0, 0, 5,  5,  32'h5555_5555, 32'h5555_5555, 2'b00, 0);
    tbl[5]  = mk(0,  0,  0,             0,  0,  0,             1, 7, 7,  5,  0,             32'h5555_5555, 2'b00, 1);
    tbl[6]  = mk(0,  0,  0,             0,  0,  0,             0, 0, 7,  1,  0,             0,             2'b01, 1);
    tbl[7]  = mk(0,  0,  0,             1,  7,  32'h42,        0, 0, 7,  7,  32'h42,        32'h42,        2'b00, 0);
    tbl[8]  = mk(0,  0,  0,             0,  0,  0,             0, 0, 7,  0,  32'h42,        0,             2'b00, 0);
    tbl[9]  = mk(1,  0,  32'hFFFF_FFFF, 0,  0,  0,             1, 0, 0,  0,  0,             0,             2'b00, 0);
    tbl[10] = mk(0,  0,  0,             0,  0,  0,             0, 0, 0,  0,  0,             0,             2'b00, 0);
    tbl[11] = mk(1,  9,  32'h99,        0,  0,  0,             1, 9, 9,  9,  32'h99,        32'h99,        2'b00, 1);
    tbl[12] = mk(0,  0,  0,             0,  0,  0,             0, 0, 9,  9,  32'h99,        32'h99,        2'b11, 1);
    tbl[13] = mk(0,  0,  0,             0,  0,  0,             1, 9, 9,  2,  32'h99,        0,             2'b01, 1);
    tbl[14] = mk(1,  9,  32'h100,       0,  0,  0,             1, 2, 9,  2,  32'h100,       0,             2'b00, 1);
    tbl[15] = mk(0,  0,  0,             1,  12, 32'hC,         0, 0, 2,  12, 0,             32'hC,         2'b01, 1);
    tbl[16] = mk(1,  2,  32'h22,        1,  2,  32'h33,        0, 0, 2,  9,  32'h33,        32'h100,       2'b00, 0);
    tbl[17] = mk(0,  0,  0,             0,  0,  0,             0, 0, 2,  12, 32'h33,        32'hC,         2'b00, 0);

    reset_n = 0;
    idle_a();
    idle_b();
    rd_addr = 0;
    #12;
    chk("rst_data", rd_data, 64'h0);
    chk("rst_busy", {62'h0, rd_busy}, 64'h0);
    chk("rst_cnt", {58'h0, busy_cnt}, 64'h0);
    reset_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      wr0_en = tbl[i].w0e; wr0_addr = tbl[i].w0a; wr0_data = tbl[i].w0d;
      wr1_en = tbl[i].w1e; wr1_addr = tbl[i].w1a; wr1_data = tbl[i].w1d;
      iss_en = tbl[i].ie;  iss_addr = tbl[i].ia;
      rd_addr = {tbl[i].ra1, tbl[i].ra0};
      #2;
      chk($sformatf("v%0d_d0", i), {32'h0, rd_data[31:0]}, {32'h0, tbl[i].ed0});
      chk($sformatf("v%0d_d1", i), {32'h0, rd_data[63:32]}, {32'h0, tbl[i].ed1});
      chk($sformatf("v%0d_busy", i), {62'h0, rd_busy}, {62'h0, tbl[i].eb});
      @(posedge clk); #1;
      chk($sformatf("v%0d_cnt", i), {58'h0, busy_cnt}, {58'h0, tbl[i].ecnt});
    end
    idle_a();

    // Parametric instance: register 0 is ordinary, four ports all read it.
    b_wr0_en = 1; b_wr0_addr = 0; b_wr0_data = 16'hBEEF;
    b_iss_en = 1; b_iss_addr = 0;
    @(posedge clk); #1;
    idle_b();
    #1;
    chk("b_data", b_rd_data, 64'hBEEF_BEEF_BEEF_BEEF);
    chk("b_busy", {60'h0, b_rd_busy}, 64'hF);
    chk("b_cnt1", {60'h0, b_busy_cnt}, 64'h1);
    b_wr1_en = 1; b_wr1_addr = 0; b_wr1_data = 16'h1234;
    #1;
    chk("b_bypass", b_rd_data, 64'h1234_1234_1234_1234);
    chk("b_busy_hit", {60'h0, b_rd_busy}, 64'h0);
    @(posedge clk); #1;
    idle_b();
    chk("b_cnt0", {60'h0, b_busy_cnt}, 64'h0);

    // Reset asserted between edges with busy bits and writes in flight.
    iss_en = 1; iss_addr = 2;
    @(posedge clk); #1;
    iss_addr = 4;
    @(posedge clk); #1;
    chk("pre_rst_cnt", {58'h0, busy_cnt}, 64'h2);
    wr0_en = 1; wr0_addr = 2; wr0_data = 32'hDEAD;
    wr1_en = 1; wr1_addr = 4; wr1_data = 32'hBEEF;
    iss_en = 1; iss_addr = 6;
    rd_addr = {5'd4, 5'd2};
    #2;
    reset_n = 0;
    #1;
    chk("rst_mid_data", rd_data, 64'h0);
    chk("rst_mid_busy", {62'h0, rd_busy}, 64'h0);
    chk("rst_mid_cnt", {58'h0, busy_cnt}, 64'h0);
    @(posedge clk); #1;
    idle_a();
    #1 reset_n = 1;
    rd_addr = {5'd12, 5'd2};
    #1;
    chk("post_rst_data", rd_data, 64'h0);
    chk("post_rst_cnt", {58'h0, busy_cnt}, 64'h0);
    wr0_en = 1; wr0_addr = 4; wr0_data = 32'h44;
    iss_en = 1; iss_addr = 6;
    @(posedge clk); #1;
    idle_a();
    rd_addr = {5'd6, 5'd4};
    #1;
    chk("first_edge_data", {32'h0, rd_data[31:0]}, 64'h44);
    chk("first_edge_busy", {62'h0, rd_busy}, 64'h2);
    chk("first_edge_cnt", {58'h0, busy_cnt}, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
